// File: rtl/ahb_lite_pkg.sv
// AHB-Lite shared types: transfer encodings,
// response codes and the memory slave FSM states.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

endpackage

// File: rtl/ahb_lite_lane_decode.sv
// Byte-lane strobes for an AHB-Lite transfer,
// little-endian, with a misaligned/illegal-size flag.
module ahb_lite_lane_decode
  import ahb_lite_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       bad
);

  hsize_e sz;

  assign sz = hsize_e'(size);

  // strobes stay zero whenever the transfer is flagged bad
  always_comb begin
    strb = 4'b0000;
    bad  = 1'b0;
    unique case (1'b1)
      (sz == SIZE_BYTE): begin
        strb = 4'b0001 << addr_lo;
      end
      (sz == SIZE_HALF): begin
        bad  = addr_lo[0];
        if (!addr_lo[0])
          strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      (sz == SIZE_WORD): begin
        bad = (addr_lo != 2'b00);
        if (addr_lo == 2'b00)
          strb = 4'b1111;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM target: word array, lane writes,
// programmable wait states, two-cycle ERROR response.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [32:0] LIMIT = 33'(MEM_DEPTH) << 2;
  localparam logic [3:0] WS_LAST =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_e state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] d_idx;
  logic [3:0]    d_strb;
  logic          d_write;
  logic [31:0]   mem [MEM_DEPTH];

  htrans_e     trans;
  logic [31:0] off;
  logic [3:0]  strb;
  logic        bad;
  logic        in_range;
  logic        err;
  logic        ready;
  logic        accept;

  ahb_lite_lane_decode u_lane (
    .size    (HSIZE),
    .addr_lo (HADDR[1:0]),
    .strb    (strb),
    .bad     (bad)
  );

  // below BASE_ADDR the offset wraps far above LIMIT
  assign trans    = htrans_e'(HTRANS);
  assign off      = HADDR - BASE_ADDR;
  assign in_range = ({1'b0, off} < LIMIT);
  assign err      = bad || !in_range;

  assign ready  = !(state == ST_WAIT || state == ST_ERR1);
  assign accept = ready &&
    (trans == TRANS_NONSEQ || trans == TRANS_SEQ);

  assign HREADY = ready;
  assign HRESP  = (state == ST_ERR1 || state == ST_ERR2)
                ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA = (state == ST_DATA && !d_write)
                ? mem[d_idx] : 32'h0;

  // state register and wait-state counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next state: stalled states advance on their own,
  // ready states follow the address phase on this edge
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_WAIT: begin
        if (cnt == WS_LAST)
          state_nx = ST_DATA;
        else
          cnt_nx = cnt + 4'd1;
      end
      ST_ERR1: begin
        state_nx = ST_ERR2;
      end
      default: begin
        state_nx = ST_IDLE;
        if (accept) begin
          cnt_nx = 4'd0;
          if (err)
            state_nx = ST_ERR1;
          else if (WAIT_STATES > 0)
            state_nx = ST_WAIT;
          else
            state_nx = ST_DATA;
        end
      end
    endcase
  end

  // address-phase capture; an erroring write never arms a write
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_idx   <= '0;
      d_strb  <= 4'b0000;
      d_write <= 1'b0;
    end else if (accept) begin
      d_idx   <= off[AW+1:2];
      d_strb  <= strb;
      d_write <= HWRITE && !err;
    end
  end

  // array write on the edge that ends the DATA cycle
  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && d_write) begin
      for (int i = 0; i < 4; i++) begin
        if (d_strb[i])
          mem[d_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench: two slaves (0 and 2 wait states) driven by a
// pipelined master, checked by a queue-fed monitor.
module tb_ahb_lite_sram_slave;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] data;
    logic        err;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic        hready [2];
  logic        hresp  [2];

  xfer_t q0[$];
  xfer_t q1[$];
  xfer_t cur   [2];
  bit    cur_v [2];
  int    cyc   [2];
  logic [7:0] mb [2][DEPTH*4];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ahb_lite_sram_slave #(
    .MEM_DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)
  ) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n),
    .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
    .HWDATA(hwdata[0]), .HRDATA(hrdata[0]),
    .HREADY(hready[0]), .HRESP(hresp[0])
  );

  ahb_lite_sram_slave #(
    .MEM_DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(32'h0)
  ) u_ws2 (
    .HCLK(clk), .HRESETn(rst_n),
    .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
    .HWDATA(hwdata[1]), .HRDATA(hrdata[1]),
    .HREADY(hready[1]), .HRESP(hresp[1])
  );

  function automatic int ws(int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic void check(string name, int k,
                                logic [31:0] act,
                                logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t",
               name, k, act, exp, $time);
    end
  endfunction

  // reference rules: range, legal size, natural alignment
  function automatic logic exp_err(logic [31:0] a,
                                   logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if (a >= 32'(DEPTH * 4)) return 1'b1;
    return (a % (32'd1 << s)) != 0;
  endfunction

  function automatic logic [31:0] model_word(int k,
                                             logic [31:0] a);
    int b;
    b = int'(a) / 4 * 4;
    return {mb[k][b+3], mb[k][b+2], mb[k][b+1], mb[k][b]};
  endfunction

  // byte-addressed memory: each written byte comes from
  // the data lane matching its address
  function automatic void model_write(int k, xfer_t x);
    int n, b;
    n = 1 << x.size;
    for (int i = 0; i < n; i++) begin
      b = int'(x.addr) + i;
      mb[k][b] = x.data[8*(b%4) +: 8];
    end
  endfunction

  // monitor: one check set per DUT per cycle
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check("rst_hready", k, 32'(hready[k]), 32'd1);
        check("rst_hresp", k, 32'(hresp[k]), 32'd0);
        check("rst_hrdata", k, hrdata[k], 32'd0);
        cur_v[k] = 1'b0;
        if (k == 0) q0.delete();
        else q1.delete();
      end else begin
        if (cur_v[k]) begin
          int fin;
          bit last;
          logic [31:0] ed;
          fin  = cur[k].err ? 1 : ws(k);
          last = (cyc[k] == fin);
          ed   = 32'h0;
          if (last && !cur[k].err && !cur[k].wr)
            ed = model_word(k, cur[k].addr);
          check("hready", k, 32'(hready[k]), 32'(last));
          check("hresp", k, 32'(hresp[k]), 32'(cur[k].err));
          check("hrdata", k, hrdata[k], ed);
          if (last) begin
            if (!cur[k].err && cur[k].wr)
              model_write(k, cur[k]);
            cur_v[k] = 1'b0;
          end else begin
            cyc[k]++;
          end
        end else begin
          check("idle_hready", k, 32'(hready[k]), 32'd1);
          check("idle_hresp", k, 32'(hresp[k]), 32'd0);
          check("idle_hrdata", k, hrdata[k], 32'd0);
        end
        if (hready[k] && htrans[k][1]) begin
          int qs;
          qs = (k == 0) ? q0.size() : q1.size();
          check("accept_expected", k, 32'(qs != 0), 32'd1);
          if (qs != 0) begin
            if (k == 0) cur[k] = q0.pop_front();
            else cur[k] = q1.pop_front();
            cur_v[k] = 1'b1;
            cyc[k]   = 0;
          end
        end
      end
    end
  end

  task automatic wait_ready(int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!hready[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", k, 32'(hready[k]), 32'd1);
  endtask

  task automatic issue(int k, logic [31:0] a,
                       logic [2:0] s, logic w,
                       logic [31:0] d);
    xfer_t x;
    haddr[k]  = a;
    hsize[k]  = s;
    hwrite[k] = w;
    htrans[k] = 2'b10;
    x.addr = a;
    x.size = s;
    x.wr   = w;
    x.data = d;
    x.err  = exp_err(a, s);
    if (k == 0) q0.push_back(x);
    else q1.push_back(x);
    wait_ready(k);
    @(posedge clk);
    #1;
    hwdata[k] = d;
  endtask

  task automatic idle(int k, logic [1:0] t);
    htrans[k] = t;
    haddr[k]  = $urandom();
    wait_ready(k);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_xfer(int k);
    int sel;
    logic [31:0] a;
    logic [2:0] s;
    logic [31:0] w;
    sel = $urandom_range(0, 99);
    w = ($urandom_range(0, 3) == 0) ? 32'd255
                                    : 32'($urandom_range(0, 15));
    s = 3'($urandom_range(0, 2));
    if (sel < 70) begin
      a = w * 4 + (32'($urandom_range(0, 3))
                   & ~((32'd1 << s) - 1));
    end else if (sel < 80) begin
      s = 3'($urandom_range(1, 2));
      a = w * 4 + ((s == 3'd1) ? 32'd1
                               : 32'($urandom_range(1, 3)));
    end else if (sel < 88) begin
      a = ($urandom_range(0, 1) == 1)
        ? 32'h400 + 32'($urandom_range(0, 65535))
        : ($urandom() | 32'h8000_0000);
    end else if (sel < 93) begin
      s = 3'($urandom_range(3, 7));
      a = w * 4;
    end else begin
      idle(k, 2'($urandom_range(0, 1)));
      return;
    end
    issue(k, a, s, 1'($urandom_range(0, 1)), $urandom());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      haddr[k]  = 32'h10;
      htrans[k] = 2'b10;
      hwrite[k] = 1'b1;
      hsize[k]  = 3'd2;
      hwdata[k] = 32'h0;
      cur_v[k]  = 1'b0;
      cyc[k]    = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    htrans[0] = 2'b00;
    htrans[1] = 2'b00;
    rst_n = 1'b1;

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++)
        issue(k, 32'(w * 4), 3'd2, 1'b1, $urandom());
      issue(k, 32'h3FC, 3'd2, 1'b1, $urandom());
      idle(k, 2'b00);

      issue(k, 32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF);
      issue(k, 32'h10, 3'd2, 1'b0, 32'h0);
      idle(k, 2'b00);

      issue(k, 32'h20, 3'd2, 1'b1, 32'h1122_3344);
      issue(k, 32'h21, 3'd0, 1'b1, 32'h0000_AA00);
      issue(k, 32'h22, 3'd1, 1'b1, 32'h5566_0000);
      issue(k, 32'h20, 3'd2, 1'b0, 32'h0);
      idle(k, 2'b00);

      issue(k, 32'h13, 3'd2, 1'b1, 32'hCAFE_F00D);
      issue(k, 32'(DEPTH * 4), 3'd2, 1'b0, 32'h0);
      issue(k, 32'h10, 3'd2, 1'b0, 32'h0);
      idle(k, 2'b00);

      for (int i = 0; i < 150; i++)
        rand_xfer(k);
      idle(k, 2'b00);
    end

    issue(1, 32'h30, 3'd2, 1'b1, 32'h0);
    idle(1, 2'b00);
    issue(1, 32'h30, 3'd2, 1'b1, 32'hFFFF_FFFF);
    htrans[1] = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hready", 1, 32'(hready[1]), 32'd1);
    check("async_rst_hresp", 1, 32'(hresp[1]), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(1, 32'h30, 3'd2, 1'b0, 32'h0);
    idle(1, 2'b00);

    repeat (3) @(negedge clk);
    check("queue0_drained", 0, 32'(q0.size()), 32'd0);
    check("queue1_drained", 1, 32'(q1.size()), 32'd0);
    check("dut0_done", 0, 32'(cur_v[0]), 32'd0);
    check("dut1_done", 1, 32'(cur_v[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
